frame_scheduler: RTL and testbench
==================================

Name: frame_scheduler

Overview:
- Sequences the per-frame update pipeline.
- On each detected screen boundary it runs game logic first, then the entities drawer, then issues a single commit pulse (new_state) that lets the entity/operational memories swap.
- Sits in the system clock domain, between the posedge-detected next_screen pulse and the game_logic / entities_drawer start/done handshakes.
- Also detects frame overruns and stalled stages.

Parameters:
- TIMEOUT_W, 20, width of the per-stage watchdog counter; a stage times out after 2^TIMEOUT_W-1 cycles.
- DIV_W, 4, width of the frame divider counter.
- FRAME_DIV, 1, run the pipeline once every FRAME_DIV accepted frames (1..2^DIV_W-1).

Ports:
- clock  in  1  system clock (clock_50 domain); the only clock.
- reset_reset  in  1  synchronous, active-high reset.
- next_screen  in  1  single-cycle pulse, already synchronized and edge-detected.
- pause  in  1  level; when high, frames are skipped.
- gl_start  out  1  one-cycle start pulse to game_logic.
- gl_done  in  1  one-cycle completion pulse from game_logic.
- ed_start  out  1  one-cycle start pulse to entities_drawer.
- ed_done  in  1  one-cycle completion pulse from entities_drawer.
- new_state  out  1  one-cycle commit pulse.
- busy  out  1  high whenever state != IDLE.
- phase  out  2  current state encoding.
- frame_overrun  out  1  sticky overrun flag.
- timeout_err  out  1  sticky watchdog flag.
- overrun_count  out  8  saturating count of dropped next_screen pulses.

Behaviour:
- Reset (sync, reset_reset=1 at a clock edge):
  - state=IDLE.
  - gl_start=ed_start=new_state=busy=0; phase=0.
  - frame_overrun=timeout_err=0; overrun_count=0; divider=0; watchdog=0.
  - Reset mid-run aborts with no commit. Done pulses in the reset cycle are ignored.
- States and phase encoding: IDLE=0, RUN_GL=1, RUN_ED=2, COMMIT=3. All outputs are registered.
- IDLE, next_screen at cycle T:
  - pause=1: frame ignored; divider unchanged; no overrun.
  - pause=0: divider increments (wraps to 0 at FRAME_DIV-1).
    - If divider was FRAME_DIV-1 before the increment: at T+1 gl_start=1 for exactly one cycle, state=RUN_GL.
    - Otherwise stay in IDLE.
- RUN_GL:
  - gl_done accepted in any cycle in this state, including the gl_start cycle.
  - gl_done at U: ed_start=1 at U+1 (one cycle), state=RUN_ED.
- RUN_ED:
  - ed_done at V: state=COMMIT and new_state=1 at V+1.
  - IDLE at V+2; new_state is exactly one cycle.
- Stray done pulses (gl_done outside RUN_GL, ed_done outside RUN_ED) are ignored.
- Watchdog:
  - Cleared on entry to RUN_GL and RUN_ED; increments each cycle in those states.
  - On reaching 2^TIMEOUT_W-1 without the expected done: timeout_err=1 (sticky), state=IDLE next cycle, no ed_start, no new_state.
  - A done arriving in the same cycle as the terminal count wins (normal progress, no error).
- Overrun:
  - next_screen while state!=IDLE (COMMIT included): pulse dropped, never queued.
  - frame_overrun=1 (sticky); overrun_count+1, saturating at 255.
  - The pipeline continues unaffected; the divider does not advance.
- Simultaneous events:
  - next_screen in the cycle state returns to IDLE from COMMIT: state is still COMMIT in that cycle, so it counts as an overrun.
  - next_screen in the cycle a timeout aborts: state is still RUN_x, so it counts as an overrun.
- pause is sampled only on next_screen in IDLE; raising it mid-run does not abort.
- FRAME_DIV=1: every unpaused frame runs.

Decomposition:
- Package frame_sched_pkg holds:
  - state enum/encodings IDLE/RUN_GL/RUN_ED/COMMIT (2 bits);
  - OVERRUN_MAX=255;
  - default TIMEOUT_W/DIV_W constants.
- Sub-module stage_watchdog (clear, enable, expired; parameter TIMEOUT_W) is instantiated once.
- The FSM, divider and overrun counter stay in frame_scheduler.

Test Plan:
1. Normal frame, FRAME_DIV=1:
   - Stimulus: next_screen@10, gl_done@20, ed_done@30.
   - Required: gl_start@11, ed_start@21, new_state@31, phase=0 @32.
   - Each pulse is one cycle; busy high over 11..31.
2. Divider, FRAME_DIV=3:
   - Stimulus: 6 unpaused next_screen pulses, each pipeline completing before the next pulse.
   - Required: gl_start only after pulses 3 and 6.
   - With pause=1 on pulse 2: gl_start only after pulses 4 (and 7).
3. Overrun:
   - Stimulus: next_screen while in RUN_GL, again in RUN_ED, again in COMMIT.
   - Required: overrun_count=3, frame_overrun=1, pipeline still commits once.
   - 300 overruns: overrun_count=255.
4. Watchdog, TIMEOUT_W=4:
   - Stimulus: no gl_done after gl_start.
   - Required: timeout_err=1, abort to IDLE 15 cycles after entering RUN_GL, no ed_start/new_state.
   - A subsequent normal frame completes; timeout_err stays 1.
5. Stray/simultaneous:
   - Stimulus: ed_done during RUN_GL.
   - Required: ignored, no commit.
   - Stimulus: gl_done in the same cycle as gl_start.
   - Required: ed_start next cycle.
   - Stimulus: gl_done coincident with watchdog terminal count.
   - Required: progresses, no timeout_err.
6. Reset mid-run:
   - Stimulus: reset_reset=1 during RUN_ED with ed_done in the same cycle.
   - Required: next cycle IDLE; all outputs and sticky flags/counters 0; no new_state.

Source files
------------

// File: rtl/frame_sched_pkg.sv
// ---------------------------------------------------------------------------
// frame_sched_pkg
// Shared types and constants for the per-frame update scheduler.
//   sched_state_t      : 2-bit scheduler state, the value is exported on 'phase'
//   OVERRUN_MAX        : saturation ceiling of the dropped-frame counter
//   DEFAULT_TIMEOUT_W  : default watchdog counter width
//   DEFAULT_DIV_W      : default frame divider width
//   DEFAULT_FRAME_DIV  : default divide ratio (run every accepted frame)
// ---------------------------------------------------------------------------
package frame_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN_GL = 2'd1,
        RUN_ED = 2'd2,
        COMMIT = 2'd3
    } sched_state_t;

    localparam logic [7:0] OVERRUN_MAX = 8'd255;

    localparam int DEFAULT_TIMEOUT_W = 20;
    localparam int DEFAULT_DIV_W     = 4;
    localparam int DEFAULT_FRAME_DIV = 1;

endpackage

// File: rtl/stage_watchdog.sv
// ---------------------------------------------------------------------------
// stage_watchdog
// Counts the cycles a pipeline stage has been running and flags the cycle in
// which the stage is spending its (2^TIMEOUT_W-1)-th cycle without finishing.
// Ports:
//   clock   in  system clock
//   reset   in  synchronous, active-high reset
//   clear   in  restart the count (asserted on the edge that enters a stage)
//   enable  in  a stage is running; count advances each cycle
//   expired out terminal count reached in this cycle (combinational from count)
// ---------------------------------------------------------------------------
module stage_watchdog
    import frame_sched_pkg::*;
#(
    parameter int TIMEOUT_W = DEFAULT_TIMEOUT_W
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // 'count' holds the number of stage cycles already completed, so it is 0
    // in the entry cycle. When it equals 2^W-2 the current cycle is the
    // (2^W-1)-th one, which is the last cycle a done pulse is still accepted.
    localparam logic [TIMEOUT_W-1:0] LAST = ~(TIMEOUT_W'(1));

    logic [TIMEOUT_W-1:0] count;

    // Clear wins over enable so that a stage-to-stage handoff restarts the
    // count. The count holds at all-ones instead of wrapping back to zero.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    assign expired = enable && (count == LAST);

endmodule

// File: rtl/frame_scheduler.sv
// ---------------------------------------------------------------------------
// frame_scheduler
// Sequences the per-frame update pipeline: on an accepted screen boundary it
// starts game_logic, then entities_drawer, then emits a one-cycle commit pulse
// that lets the entity/operational memories swap. Detects dropped frames
// (overruns) and stalled stages (watchdog timeouts).
// Ports:
//   clock          in   system clock
//   reset_reset    in   synchronous, active-high reset
//   next_screen    in   one-cycle screen boundary pulse
//   pause          in   level; frames arriving while high are skipped
//   gl_start       out  one-cycle start pulse to game_logic
//   gl_done        in   one-cycle completion pulse from game_logic
//   ed_start       out  one-cycle start pulse to entities_drawer
//   ed_done        in   one-cycle completion pulse from entities_drawer
//   new_state      out  one-cycle commit pulse
//   busy           out  high whenever the scheduler is not idle
//   phase          out  current state encoding (IDLE/RUN_GL/RUN_ED/COMMIT)
//   frame_overrun  out  sticky: a boundary arrived while busy
//   timeout_err    out  sticky: a stage exceeded its watchdog budget
//   overrun_count  out  saturating count of dropped boundaries
// ---------------------------------------------------------------------------
module frame_scheduler
    import frame_sched_pkg::*;
#(
    parameter int TIMEOUT_W = DEFAULT_TIMEOUT_W,
    parameter int DIV_W     = DEFAULT_DIV_W,
    parameter int FRAME_DIV = DEFAULT_FRAME_DIV
) (
    input  logic       clock,
    input  logic       reset_reset,
    input  logic       next_screen,
    input  logic       pause,
    output logic       gl_start,
    input  logic       gl_done,
    output logic       ed_start,
    input  logic       ed_done,
    output logic       new_state,
    output logic       busy,
    output logic [1:0] phase,
    output logic       frame_overrun,
    output logic       timeout_err,
    output logic [7:0] overrun_count
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    sched_state_t     state;
    logic [DIV_W-1:0] divider;
    logic             frame_go;
    logic             wd_clear;
    logic             wd_enable;
    logic             wd_expired;

    // An unpaused boundary in IDLE that completes a divider period launches
    // the pipeline. The watchdog restarts on every edge that enters a stage.
    assign frame_go  = (state == IDLE) && next_screen && !pause && (divider == DIV_LAST);
    assign wd_clear  = frame_go || ((state == RUN_GL) && gl_done);
    assign wd_enable = (state == RUN_GL) || (state == RUN_ED);

    stage_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset_reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // The state register is itself the phase output, so phase is registered.
    assign phase = state;

    // Main sequencer. Start/commit pulses default low each cycle and are set
    // only on the transition that produces them. A done pulse is checked
    // before the watchdog so that a completion on the terminal cycle counts as
    // normal progress. Boundaries arriving while busy are dropped and counted
    // independently of whatever transition the state takes in that cycle.
    always_ff @(posedge clock) begin
        if (reset_reset) begin
            state         <= IDLE;
            divider       <= '0;
            gl_start      <= 1'b0;
            ed_start      <= 1'b0;
            new_state     <= 1'b0;
            busy          <= 1'b0;
            frame_overrun <= 1'b0;
            timeout_err   <= 1'b0;
            overrun_count <= '0;
        end else begin
            gl_start  <= 1'b0;
            ed_start  <= 1'b0;
            new_state <= 1'b0;

            if (next_screen && (state != IDLE)) begin
                frame_overrun <= 1'b1;
                if (overrun_count != OVERRUN_MAX) begin
                    overrun_count <= overrun_count + 8'd1;
                end
            end

            case (state)
                IDLE: begin
                    if (next_screen && !pause) begin
                        if (divider == DIV_LAST) begin
                            divider  <= '0;
                            state    <= RUN_GL;
                            gl_start <= 1'b1;
                            busy     <= 1'b1;
                        end else begin
                            divider <= divider + DIV_W'(1);
                        end
                    end
                end
                RUN_GL: begin
                    if (gl_done) begin
                        state    <= RUN_ED;
                        ed_start <= 1'b1;
                    end else if (wd_expired) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                RUN_ED: begin
                    if (ed_done) begin
                        state     <= COMMIT;
                        new_state <= 1'b1;
                    end else if (wd_expired) begin
                        state       <= IDLE;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                    end
                end
                COMMIT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_scheduler
// Bench for frame_scheduler. Two instances share the stimulus: dut_a runs
// every frame (FRAME_DIV=1), dut_b every third frame (FRAME_DIV=3). Both use a
// 4-bit watchdog so a stalled stage aborts after 15 cycles in that stage.
// Inputs change 1 ns after a rising edge; outputs are read at the same point,
// so a value read after tick() is the one registered on that edge.
// ---------------------------------------------------------------------------
module tb_frame_scheduler;

    logic       clock = 1'b0;
    logic       reset_reset = 1'b0;
    logic       next_screen = 1'b0;
    logic       pause = 1'b0;
    logic       gl_done = 1'b0;
    logic       ed_done = 1'b0;

    logic       a_gl_start, a_ed_start, a_new_state, a_busy;
    logic [1:0] a_phase;
    logic       a_frame_overrun, a_timeout_err;
    logic [7:0] a_overrun_count;

    logic       b_gl_start, b_ed_start, b_new_state, b_busy;
    logic [1:0] b_phase;
    logic       b_frame_overrun, b_timeout_err;
    logic [7:0] b_overrun_count;

    int errors = 0;
    int checks = 0;

    int a_commits = 0;
    int a_gl_starts = 0;
    int a_ed_starts = 0;

    always #5 clock = ~clock;

    frame_scheduler #(.TIMEOUT_W(4), .DIV_W(4), .FRAME_DIV(1)) dut_a (
        .clock         (clock),
        .reset_reset   (reset_reset),
        .next_screen   (next_screen),
        .pause         (pause),
        .gl_start      (a_gl_start),
        .gl_done       (gl_done),
        .ed_start      (a_ed_start),
        .ed_done       (ed_done),
        .new_state     (a_new_state),
        .busy          (a_busy),
        .phase         (a_phase),
        .frame_overrun (a_frame_overrun),
        .timeout_err   (a_timeout_err),
        .overrun_count (a_overrun_count)
    );

    frame_scheduler #(.TIMEOUT_W(4), .DIV_W(4), .FRAME_DIV(3)) dut_b (
        .clock         (clock),
        .reset_reset   (reset_reset),
        .next_screen   (next_screen),
        .pause         (pause),
        .gl_start      (b_gl_start),
        .gl_done       (gl_done),
        .ed_start      (b_ed_start),
        .ed_done       (ed_done),
        .new_state     (b_new_state),
        .busy          (b_busy),
        .phase         (b_phase),
        .frame_overrun (b_frame_overrun),
        .timeout_err   (b_timeout_err),
        .overrun_count (b_overrun_count)
    );

    // Pulse tallies for dut_a, used to confirm a pulse happened exactly once.
    always @(posedge clock) begin
        if (a_new_state === 1'b1) a_commits   <= a_commits + 1;
        if (a_gl_start  === 1'b1) a_gl_starts <= a_gl_starts + 1;
        if (a_ed_start  === 1'b1) a_ed_starts <= a_ed_starts + 1;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        next_screen = 1'b0;
        pause       = 1'b0;
        gl_done     = 1'b0;
        ed_done     = 1'b0;
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
    endtask

    // One boundary for dut_b; if dut_b launched, completes its pipeline.
    task automatic frame_b(input bit p, output bit started);
        pause = p;
        next_screen = 1'b1;
        tick();
        next_screen = 1'b0;
        pause = 1'b0;
        started = (b_gl_start === 1'b1);
        if (started) begin
            gl_done = 1'b1; tick(); gl_done = 1'b0;
            ed_done = 1'b1; tick(); ed_done = 1'b0;
            tick();
        end else begin
            tick();
            tick();
        end
    endtask

    task automatic test_reset();
        next_screen = 1'b1;
        gl_done = 1'b1;
        ed_done = 1'b1;
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        next_screen = 1'b0;
        gl_done = 1'b0;
        ed_done = 1'b0;
        checks++; if (a_phase !== 2'd0) begin errors++; $display("[TB] FAIL reset_phase: got %0d expected 0", a_phase); end
        checks++; if ({a_gl_start, a_ed_start, a_new_state, a_busy} !== 4'b0000) begin errors++; $display("[TB] FAIL reset_pulses: got %b expected 0000", {a_gl_start, a_ed_start, a_new_state, a_busy}); end
        checks++; if ({a_frame_overrun, a_timeout_err} !== 2'b00) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 00", {a_frame_overrun, a_timeout_err}); end
        checks++; if (a_overrun_count !== 8'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", a_overrun_count); end
        checks++; if ({b_phase, b_busy} !== 3'b000) begin errors++; $display("[TB] FAIL reset_b_state: got %b expected 000", {b_phase, b_busy}); end
    endtask

    task automatic test_normal_frame();
        int bad;
        int c0;
        do_reset();
        repeat (9) tick();
        c0 = a_commits;
        next_screen = 1'b1;
        tick();
        next_screen = 1'b0;
        checks++; if ({a_gl_start, a_busy, a_phase} !== 4'b1101) begin errors++; $display("[TB] FAIL normal_gl_start: got %b expected 1101", {a_gl_start, a_busy, a_phase}); end
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (a_gl_start !== 1'b0 || a_busy !== 1'b1 || a_phase !== 2'd1) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL normal_run_gl_hold: got %0d bad cycles expected 0", bad); end
        gl_done = 1'b1;
        tick();
        gl_done = 1'b0;
        checks++; if ({a_ed_start, a_busy, a_phase} !== 4'b1110) begin errors++; $display("[TB] FAIL normal_ed_start: got %b expected 1110", {a_ed_start, a_busy, a_phase}); end
        bad = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            if (a_ed_start !== 1'b0 || a_new_state !== 1'b0 || a_busy !== 1'b1 || a_phase !== 2'd2) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL normal_run_ed_hold: got %0d bad cycles expected 0", bad); end
        ed_done = 1'b1;
        tick();
        ed_done = 1'b0;
        checks++; if ({a_new_state, a_busy, a_phase} !== 4'b1111) begin errors++; $display("[TB] FAIL normal_commit: got %b expected 1111", {a_new_state, a_busy, a_phase}); end
        tick();
        checks++; if ({a_new_state, a_busy, a_phase} !== 4'b0000) begin errors++; $display("[TB] FAIL normal_back_idle: got %b expected 0000", {a_new_state, a_busy, a_phase}); end
        checks++; if (a_commits - c0 != 1) begin errors++; $display("[TB] FAIL normal_commit_count: got %0d expected 1", a_commits - c0); end
    endtask

    task automatic test_divider();
        bit started;
        bit expect_start;
        int accepted;
        bit paused;
        do_reset();
        for (int i = 1; i <= 6; i++) begin
            frame_b(1'b0, started);
            expect_start = (i % 3 == 0);
            checks++; if (started != expect_start) begin errors++; $display("[TB] FAIL divider_pulse%0d: got %0d expected %0d", i, started, expect_start); end
        end
        do_reset();
        accepted = 0;
        for (int i = 1; i <= 7; i++) begin
            paused = (i == 2);
            expect_start = !paused && (accepted % 3 == 2);
            if (!paused) accepted++;
            frame_b(paused, started);
            checks++; if (started != expect_start) begin errors++; $display("[TB] FAIL divider_pause_pulse%0d: got %0d expected %0d", i, started, expect_start); end
        end
    endtask

    task automatic test_overrun();
        int c0;
        int s0;
        do_reset();
        c0 = a_commits;
        next_screen = 1'b1; tick();
        next_screen = 1'b1; tick();
        next_screen = 1'b0;
        gl_done = 1'b1; tick(); gl_done = 1'b0;
        next_screen = 1'b1; tick(); next_screen = 1'b0;
        ed_done = 1'b1; tick(); ed_done = 1'b0;
        next_screen = 1'b1; tick(); next_screen = 1'b0;
        checks++; if (a_overrun_count !== 8'd3) begin errors++; $display("[TB] FAIL overrun_count3: got %0d expected 3", a_overrun_count); end
        checks++; if (a_frame_overrun !== 1'b1) begin errors++; $display("[TB] FAIL overrun_flag: got %b expected 1", a_frame_overrun); end
        tick();
        checks++; if (a_commits - c0 != 1) begin errors++; $display("[TB] FAIL overrun_commit_once: got %0d expected 1", a_commits - c0); end
        checks++; if (a_phase !== 2'd0) begin errors++; $display("[TB] FAIL overrun_not_queued: got phase %0d expected 0", a_phase); end

        do_reset();
        s0 = a_gl_starts;
        for (int f = 0; f < 30; f++) begin
            next_screen = 1'b1;
            tick();
            for (int k = 0; k < 10; k++) begin
                next_screen = 1'b1;
                gl_done = (k == 9);
                tick();
            end
            next_screen = 1'b0;
            gl_done = 1'b0;
            ed_done = 1'b1; tick(); ed_done = 1'b0;
            tick();
            if (f == 24) begin
                checks++; if (a_overrun_count !== 8'd250) begin errors++; $display("[TB] FAIL overrun_count250: got %0d expected 250", a_overrun_count); end
            end
        end
        checks++; if (a_overrun_count !== 8'd255) begin errors++; $display("[TB] FAIL overrun_saturate: got %0d expected 255", a_overrun_count); end
        checks++; if (a_gl_starts - s0 != 30) begin errors++; $display("[TB] FAIL overrun_frames_run: got %0d expected 30", a_gl_starts - s0); end
    endtask

    task automatic test_stray();
        int c0;
        do_reset();
        c0 = a_commits;
        gl_done = 1'b1; tick(); gl_done = 1'b0;
        ed_done = 1'b1; tick(); ed_done = 1'b0;
        checks++; if ({a_phase, a_ed_start, a_new_state} !== 4'b0000) begin errors++; $display("[TB] FAIL stray_idle: got %b expected 0000", {a_phase, a_ed_start, a_new_state}); end
        next_screen = 1'b1; tick(); next_screen = 1'b0;
        ed_done = 1'b1; tick(); ed_done = 1'b0;
        checks++; if ({a_phase, a_new_state} !== 3'b010) begin errors++; $display("[TB] FAIL stray_ed_in_gl: got %b expected 010", {a_phase, a_new_state}); end
        tick();
        checks++; if (a_commits != c0) begin errors++; $display("[TB] FAIL stray_no_commit: got %0d expected 0", a_commits - c0); end
        gl_done = 1'b1; tick();
        tick(); gl_done = 1'b0;
        checks++; if ({a_phase, a_ed_start} !== 3'b100) begin errors++; $display("[TB] FAIL stray_gl_in_ed: got %b expected 100", {a_phase, a_ed_start}); end
        ed_done = 1'b1; tick(); ed_done = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        next_screen = 1'b1; tick(); next_screen = 1'b0;
        gl_done = 1'b1; tick(); gl_done = 1'b0;
        checks++; if ({a_ed_start, a_phase} !== 3'b110) begin errors++; $display("[TB] FAIL same_cycle_gl_done: got %b expected 110", {a_ed_start, a_phase}); end
        ed_done = 1'b1; tick(); ed_done = 1'b0;
        checks++; if (a_new_state !== 1'b1) begin errors++; $display("[TB] FAIL same_cycle_ed_done: got %b expected 1", a_new_state); end
        tick();
    endtask

    task automatic test_watchdog();
        int bad;
        int c0;
        int e0;
        do_reset();
        c0 = a_commits;
        e0 = a_ed_starts;
        next_screen = 1'b1; tick(); next_screen = 1'b0;
        bad = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (a_phase !== 2'd1 || a_timeout_err !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL wd_early_abort: got %0d bad cycles expected 0", bad); end
        tick();
        checks++; if ({a_phase, a_busy, a_timeout_err} !== 4'b0001) begin errors++; $display("[TB] FAIL wd_abort: got %b expected 0001", {a_phase, a_busy, a_timeout_err}); end
        tick();
        checks++; if (a_commits != c0 || a_ed_starts != e0) begin errors++; $display("[TB] FAIL wd_no_progress: got commits %0d ed %0d expected 0 0", a_commits - c0, a_ed_starts - e0); end
        next_screen = 1'b1; tick(); next_screen = 1'b0;
        gl_done = 1'b1; tick(); gl_done = 1'b0;
        ed_done = 1'b1; tick(); ed_done = 1'b0;
        tick();
        checks++; if (a_commits - c0 != 1 || a_timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL wd_recover: got commits %0d err %b expected 1 1", a_commits - c0, a_timeout_err); end
    endtask

    task automatic test_reset_midrun();
        int c0;
        next_screen = 1'b1; tick();
        next_screen = 1'b1; tick(); next_screen = 1'b0;
        gl_done = 1'b1; tick(); gl_done = 1'b0;
        c0 = a_commits;
        ed_done = 1'b1;
        reset_reset = 1'b1;
        tick();
        reset_reset = 1'b0;
        ed_done = 1'b0;
        checks++; if ({a_phase, a_busy, a_new_state, a_ed_start} !== 5'b00000) begin errors++; $display("[TB] FAIL midrun_state: got %b expected 00000", {a_phase, a_busy, a_new_state, a_ed_start}); end
        checks++; if ({a_frame_overrun, a_timeout_err, a_overrun_count} !== 10'd0) begin errors++; $display("[TB] FAIL midrun_sticky: got %b %b %0d expected 0 0 0", a_frame_overrun, a_timeout_err, a_overrun_count); end
        tick();
        checks++; if (a_commits != c0 || a_phase !== 2'd0) begin errors++; $display("[TB] FAIL midrun_no_commit: got commits %0d phase %0d expected 0 0", a_commits - c0, a_phase); end
    endtask

    task automatic test_wd_coincident();
        do_reset();
        next_screen = 1'b1; tick(); next_screen = 1'b0;
        repeat (14) tick();
        gl_done = 1'b1; tick(); gl_done = 1'b0;
        checks++; if ({a_ed_start, a_phase, a_timeout_err} !== 4'b1100) begin errors++; $display("[TB] FAIL wd_coincident_gl: got %b expected 1100", {a_ed_start, a_phase, a_timeout_err}); end
        repeat (14) tick();
        ed_done = 1'b1; tick(); ed_done = 1'b0;
        checks++; if ({a_new_state, a_phase, a_timeout_err} !== 4'b1110) begin errors++; $display("[TB] FAIL wd_coincident_ed: got %b expected 1110", {a_new_state, a_phase, a_timeout_err}); end
        tick();
    endtask

    // Random frames on dut_b: the expected launch pattern comes from counting
    // unpaused boundaries; every boundary raised while busy adds one overrun.
    task automatic test_random();
        int accepted;
        int exp_ovr;
        int bad;
        int exp_cnt;
        do_reset();
        accepted = 0;
        exp_ovr = 0;
        bad = 0;
        for (int f = 0; f < 40; f++) begin
            bit p;
            bit exp_start;
            int gl_lat;
            int ed_lat;
            p = ($urandom_range(0, 3) == 0);
            gl_lat = $urandom_range(0, 5);
            ed_lat = $urandom_range(0, 5);
            exp_start = !p && (accepted % 3 == 2);
            if (!p) accepted++;
            pause = p;
            next_screen = 1'b1;
            tick();
            next_screen = 1'b0;
            pause = 1'b0;
            checks++; if (b_gl_start !== exp_start) begin errors++; $display("[TB] FAIL rand_start_f%0d: got %b expected %b", f, b_gl_start, exp_start); end
            if (exp_start) begin
                for (int i = 0; i <= gl_lat; i++) begin
                    next_screen = ($urandom_range(0, 2) == 0);
                    if (next_screen) exp_ovr++;
                    gl_done = (i == gl_lat);
                    tick();
                end
                next_screen = 1'b0;
                gl_done = 1'b0;
                if (b_ed_start !== 1'b1) bad++;
                for (int i = 0; i <= ed_lat; i++) begin
                    next_screen = ($urandom_range(0, 2) == 0);
                    if (next_screen) exp_ovr++;
                    ed_done = (i == ed_lat);
                    tick();
                end
                next_screen = 1'b0;
                ed_done = 1'b0;
                if (b_new_state !== 1'b1) bad++;
                next_screen = ($urandom_range(0, 1) == 0);
                if (next_screen) exp_ovr++;
                tick();
                next_screen = 1'b0;
                if (b_phase !== 2'd0 || b_new_state !== 1'b0) bad++;
            end else begin
                tick();
            end
        end
        exp_cnt = (exp_ovr > 255) ? 255 : exp_ovr;
        checks++; if (bad != 0) begin errors++; $display("[TB] FAIL rand_pipeline: got %0d bad steps expected 0", bad); end
        checks++; if (b_overrun_count !== 8'(exp_cnt)) begin errors++; $display("[TB] FAIL rand_overrun_count: got %0d expected %0d", b_overrun_count, exp_cnt); end
        checks++; if (b_frame_overrun !== (exp_ovr != 0)) begin errors++; $display("[TB] FAIL rand_overrun_flag: got %b expected %b", b_frame_overrun, (exp_ovr != 0)); end
    endtask

    initial begin
        $display("[TB] frame_scheduler bench start");
        test_reset();
        test_normal_frame();
        test_divider();
        test_overrun();
        test_stray();
        test_back_to_back();
        test_watchdog();
        test_reset_midrun();
        test_wd_coincident();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL global_timeout: got no completion expected finish before 2 ms");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
